timer_dev: RTL and testbench

Memory-mapped programmable countdown timer that acts as a responder on the CPU's load/store interface. The pipeline's MEM stage drives it the same way it drives DM, gated by a device select from the system address decoder. It exposes three word registers (control, preset, live count) and raises an interrupt request when a countdown completes. It supports one-shot and auto-reload modes.

---
 rtl/timer_dev_pkg.sv | 28 ++
 rtl/timer_dev.sv | 106 ++++++++++
 tb/tb_timer_dev.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, CTRL bit positions and mode codes.
package timer_dev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Only this code reloads; every other MODE value behaves as one-shot.
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  function automatic logic mode_is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Programmable countdown timer on the CPU load/store bus: CTRL/PRESET/COUNT
// registers, one-shot or auto-reload countdown, masked interrupt request.
//
// state | meaning
// IDLE  | stopped, COUNT frozen; waits for EN
// LOAD  | copies PRESET into COUNT
// CNT   | decrements COUNT once per cycle while EN
// INT   | countdown done; one-shot drops EN, auto-reload goes back to LOAD
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state, state_nxt;
  logic [3:0]       ctrl;
  logic [CNT_W-1:0] preset, count, count_nxt;
  logic             irq_flag;
  logic             flag_set, flag_clr_fsm, en_clr;
  logic             wr_ctrl, wr_preset;
  logic             unused_wdata;

  assign wr_ctrl      = sel & we & (addr == ADDR_CTRL);
  assign wr_preset    = sel & we & (addr == ADDR_PRESET);
  assign unused_wdata = ^wdata;

  // Next-state logic sees the pre-write register values of this cycle.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    flag_set     = 1'b0;
    flag_clr_fsm = 1'b0;
    en_clr       = 1'b0;
    case (state)
      ST_IDLE: if (ctrl[CTRL_EN]) state_nxt = ST_LOAD;
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl[CTRL_EN]) begin
          state_nxt = ST_IDLE;
        end else if (count <= CNT_ONE) begin
          count_nxt = '0;
          flag_set  = 1'b1;
          state_nxt = ST_INT;
        end else begin
          count_nxt = count - CNT_ONE;
        end
      end
      ST_INT: begin
        if (mode_is_reload(ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
          flag_clr_fsm = 1'b1;
          state_nxt    = ST_LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // A software CTRL write takes precedence over the hardware EN drop.
      if (wr_ctrl)     ctrl          <= wdata[3:0];
      else if (en_clr) ctrl[CTRL_EN] <= 1'b0;
      if (wr_preset) preset <= wdata[CNT_W-1:0];
      if (flag_set)                                     irq_flag <= 1'b1;
      else if (wr_ctrl || wr_preset || flag_clr_fsm)    irq_flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL:   rdata[3:0]       = ctrl;
      ADDR_PRESET: rdata[CNT_W-1:0] = preset;
      ADDR_COUNT:  rdata[CNT_W-1:0] = count;
      default:     rdata            = '0;
    endcase
  end

  assign irq = ctrl[CTRL_IM] & irq_flag;

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: directed scenarios then random bus traffic,
// checked every cycle against a behavioural timer model.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset, sel, we;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic        irq;

  timer_dev #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        irq;
    int          cyc;
    logic [1:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_n   = 0;

  // Behavioural model: register contents plus where the countdown stands.
  bit          m_known = 0;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  bit          m_flag, m_loading, m_running, m_expired;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    if (a == 2'd0) return {28'd0, m_ctrl};
    if (a == 2'd1) return m_preset;
    if (a == 2'd2) return m_count;
    return 32'd0;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit w,
                            input logic [1:0] a, input logic [31:0] d);
    bit en, reload, set_f, clr_f, drop_en;
    if (r) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 0;
      m_loading = 0; m_running = 0; m_expired = 0; m_known = 1;
      return;
    end
    en      = m_ctrl[0];
    reload  = (m_ctrl[2:1] == 2'b01);
    set_f   = 0;
    clr_f   = 0;
    drop_en = 0;
    if (m_expired) begin
      m_expired = 0;
      if (reload) begin
        clr_f     = 1;
        m_loading = 1;
      end else begin
        drop_en = 1;
      end
    end else if (m_loading) begin
      m_count   = m_preset;
      m_loading = 0;
      m_running = 1;
    end else if (m_running) begin
      if (!en) m_running = 0;
      else if (m_count <= 1) begin
        m_count   = 0;
        set_f     = 1;
        m_running = 0;
        m_expired = 1;
      end else begin
        m_count = m_count - 1;
      end
    end else if (en) begin
      m_loading = 1;
    end
    if (s && w && a == 2'd0) begin
      m_ctrl = d[3:0];
      clr_f  = 1;
    end else if (drop_en) begin
      m_ctrl[0] = 1'b0;
    end
    if (s && w && a == 2'd1) begin
      m_preset = d;
      clr_f    = 1;
    end
    if (set_f)      m_flag = 1;
    else if (clr_f) m_flag = 0;
  endtask

  task automatic cyc(input bit r, input bit s, input bit w,
                     input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    reset = r; sel = s; we = w; addr = a; wdata = d;
    if (m_known) begin
      e.rdata = m_read(a);
      e.irq   = m_ctrl[3] & m_flag;
      e.cyc   = cyc_n;
      e.addr  = a;
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_step(r, s, w, a, d);
    cyc_n++;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(0, 1, 1, a, d);
  endtask

  task automatic rd(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, a, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (rdata !== e.rdata || irq !== e.irq) begin
        n_fail++;
        $display("FAIL cycle %0d addr=%0d: rdata=%h irq=%b, expected rdata=%h irq=%b",
                 e.cyc, e.addr, rdata, irq, e.rdata, e.irq);
      end
    end
  end

  initial begin
    int          k;
    logic [1:0]  ra;
    logic [31:0] rdv;

    repeat (3) cyc(1, 0, 0, 2'd0, 32'd0);
    for (int a = 0; a < 4; a++) rd(2'(a), 1);

    // one-shot, IM set
    wr(2'd1, 32'd5); wr(2'd0, 32'h9);
    rd(2'd2, 12); rd(2'd0, 2); wr(2'd0, 32'h0); rd(2'd0, 2);

    // auto-reload with and without IM
    wr(2'd1, 32'd3); wr(2'd0, 32'hB); rd(2'd2, 24);
    wr(2'd0, 32'h3); rd(2'd2, 12); wr(2'd0, 32'h0); rd(2'd2, 3);

    // pause, resume, COUNT write, PRESET write mid-count
    wr(2'd1, 32'd20); wr(2'd0, 32'h1); rd(2'd2, 8);
    wr(2'd0, 32'h0); rd(2'd2, 5); wr(2'd0, 32'h1); rd(2'd2, 6);
    wr(2'd2, 32'h55); rd(2'd2, 2); wr(2'd1, 32'd4); rd(2'd2, 4); rd(2'd1, 1);
    wr(2'd0, 32'h0); rd(2'd2, 2);

    // PRESET = 0
    wr(2'd1, 32'd0); wr(2'd0, 32'h9); rd(2'd2, 6); wr(2'd0, 32'h0); rd(2'd0, 2);

    // CTRL write landing on the INT-entry edge
    wr(2'd1, 32'd3); wr(2'd0, 32'h9); rd(2'd2, 4); wr(2'd0, 32'hB); rd(2'd0, 8);
    wr(2'd0, 32'h0);

    // reset during CNT
    wr(2'd1, 32'd9); wr(2'd0, 32'h9); rd(2'd2, 5);
    cyc(1, 0, 0, 2'd2, 32'd0); rd(2'd2, 15); rd(2'd0, 1);

    for (int i = 0; i < 3000; i++) begin
      k   = int'($urandom_range(0, 99));
      ra  = 2'($urandom_range(0, 3));
      rdv = $urandom;
      if (ra == 2'd1 && $urandom_range(0, 7) != 0) rdv = $urandom_range(0, 12);
      if (k == 0)      cyc(1, 0, 0, ra, rdv);
      else if (k < 15) cyc(0, 1, 1, ra, rdv);
      else if (k < 20) cyc(0, 0, 1, ra, rdv);
      else             cyc(0, 1'($urandom_range(0, 1)), 0, ra, rdv);
    end

    sel = 0; we = 0; reset = 0;
    @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
